imem_responder: RTL and testbench
=================================

# imem_responder

Instruction-memory responder: the memory end of the fetch interface whose initiator is the core's program-counter register. It accepts word fetch requests on a valid/ready channel, reads a synchronous on-chip instruction memory, and returns the instruction, echoed address and fault code on a valid/ready response channel. It sustains one fetch per cycle under no backpressure. A flush input discards stale responses on a branch redirect, and a loader port programs the memory at boot.

## Interface

- `DEPTH_WORDS`, 1024: memory size in 32-bit words; must be a power of two.
- `AW`, `$clog2(DEPTH_WORDS)`: word-address width; derived, not overridden.
- `NOP_INSTR`, 32'h0000_0013: instruction word returned on a fault.

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `req_valid` in 1: fetch request present.
- `req_ready` out 1: request accepted when high together with `req_valid`.
- `req_addr` in 32: byte address from the PC.
- `rsp_valid` out 1: response present.
- `rsp_ready` in 1: consumer takes the response.
- `rsp_instr` out 32: instruction word.
- `rsp_addr` out 32: byte address of this response.
- `rsp_fault` out 2: 00 ok, 01 misaligned, 10 out-of-range.
- `flush` in 1: drop all accepted-but-undelivered fetches.
- `ld_en` in 1: loader write strobe.
- `ld_addr` in AW: loader word address.
- `ld_data` in 32: loader write data.

## Operation

- **Accept.** A request is accepted on `req_valid && req_ready`. `req_ready = !ld_en && (fifo_count + s1_valid) < 3`. The ready term is built from registered state only, plus `ld_en`; there is no path from `rsp_ready` to `req_ready`.
- **Stage 1 (registered on accept).** Holds `s1_valid`, `s1_addr` and `s1_fault`; the memory read is issued with `req_addr[AW+1:2]`.
- **Fault classification at accept.**
  - Misaligned: `req_addr[1:0] != 0`. Takes priority over out-of-range.
  - Out-of-range: `req_addr[31:2] >= DEPTH_WORDS`.
  - Faulted entries carry `NOP_INSTR` in place of the memory data.
- **Stage 2.** In the cycle after accept, memory data (or `NOP_INSTR`), address and fault are pushed into a 3-entry response FIFO.
- **Response.** The FIFO head drives the `rsp_*` outputs. `rsp_valid = (fifo_count != 0)`. The entry is popped on `rsp_valid && rsp_ready`. Responses are delivered strictly in request order.
- **Stability under backpressure.** While `rsp_valid && !rsp_ready`, all `rsp_*` outputs hold stable.
- **Flush.**
  - Clears `s1_valid` and empties the FIFO in the same edge; no pop is performed.
  - A request accepted in the flush cycle is retained. It is the redirect target and becomes the new `s1`.
- **Loader.**
  - `ld_en` writes `ld_data` to `mem[ld_addr]` at the edge and forces `req_ready` low.
  - Entries already in `s1` or the FIFO complete normally.
  - A read issued in the cycle after a write to the same word returns the new data.
- **Memory.** Memory contents are not reset.

## Timing

- **Reset values** (`rst` low): `s1_valid=0`, `fifo_count=0`, `rsp_valid=0`, `rsp_instr=0`, `rsp_addr=0`, `rsp_fault=0`, `req_ready=0`.
  - `req_ready` rises in the first cycle after `rst` deasserts, provided `ld_en=0`.
- **Latency.** A request accepted in cycle t produces `rsp_valid` in cycle t+2 when the FIFO was empty.
- **Throughput.** One response per cycle while `rsp_ready=1`. Steady state: `s1_valid=1`, `fifo_count=1`.
- **Full backpressure.** At most 3 requests are accepted beyond the last pop; `req_ready` then stays 0 until a pop or a flush.
- **Simultaneous push and pop.** `fifo_count` is unchanged.
- **Flush with `rsp_ready=1`.** The flush wins; the head is discarded, not delivered.
- **Reset mid-operation.** All in-flight entries are dropped immediately (asynchronous); the memory array is untouched.
- **Fifo index wrap-around.** Pointers are mod-3 counters (0,1,2,0). Full is `count==3`; empty is `count==0`.

## Structure

- **Package `imem_pkg`:**
  - fault code constants `FAULT_OK=2'b00`, `FAULT_MISALIGN=2'b01`, `FAULT_RANGE=2'b10`;
  - `NOP_INSTR` default;
  - response entry typedef {instr[31:0], addr[31:0], fault[1:0]}.
- **Sub-module `imem_rsp_fifo`:**
  - 3-entry FIFO of response entries;
  - push/pop/flush inputs, count output;
  - asynchronous active-low reset.
- **Memory.** The memory is an inferred synchronous-read array in `imem_responder`, written only by the loader port.

## Test plan

- **Load and stream.** Load `mem[0..3]` = 32'h00500093, 32'h00100113, 32'h002081B3, 32'h00000013, then fetch addresses 0,4,8,12 back-to-back with `rsp_ready=1`. Required: four responses in consecutive cycles starting 2 cycles after the first accept, correct words, fault 00.
- **Backpressure.** Hold `rsp_ready=0` and offer 5 requests. Required: exactly 3 accepted, then `req_ready=0`. Release `rsp_ready`: responses arrive in order, outputs stable while stalled, a 4th request is accepted after the first pop.
- **Faults.** Request address 32'h6 → fault 01, `rsp_instr`=32'h00000013. Request address 32'h1000 with DEPTH 1024 → fault 10. Request 32'h1002 → fault 01 (misaligned has priority).
- **Flush with redirect.** With 2 entries in the FIFO plus `s1_valid`, assert `flush` together with a request to 32'h20. Required: the next response is `mem[8]` at `rsp_addr`=32'h20; no older response appears.
- **Loader conflict and reset.** Assert `ld_en` while `req_valid=1`: `req_ready=0` for that cycle. A write to word 5 followed next cycle by a fetch of 32'h14 returns the new data. Asserting `rst` mid-stream clears `rsp_valid` and `req_ready` asynchronously, and memory contents persist.

Source files
------------

// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

  localparam logic [1:0] FAULT_OK       = 2'b00;
  localparam logic [1:0] FAULT_MISALIGN = 2'b01;
  localparam logic [1:0] FAULT_RANGE    = 2'b10;

  // Canonical RV32I NOP (addi x0, x0, 0) returned in place of faulted fetches.
  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0013;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
  } rsp_entry_t;

endpackage

// File: rtl/imem_rsp_fifo.sv
// Three-entry response FIFO with mod-3 pointers; flush empties it in one edge.
module imem_rsp_fifo
  import imem_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       push,
  input  rsp_entry_t push_entry,
  input  logic       pop,
  input  logic       flush,
  output rsp_entry_t head,
  output logic [1:0] count
);

  rsp_entry_t entries [3];
  logic [1:0] wr_ptr;
  logic [1:0] rd_ptr;
  logic       do_push;
  logic       do_pop;

  function automatic logic [1:0] next_ptr(input logic [1:0] p);
    return (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  // Flush beats both push and pop; a pop on an empty FIFO is ignored.
  assign do_push = push && !flush && (count != 2'd3);
  assign do_pop  = pop && !flush && (count != 2'd0);
  assign head    = entries[rd_ptr];

  // Pointer and occupancy bookkeeping.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else if (flush) begin
      wr_ptr <= 2'd0;
      rd_ptr <= 2'd0;
      count  <= 2'd0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage; data only, never reset.
  always_ff @(posedge clk) begin
    if (do_push) entries[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/imem_responder.sv
// Instruction-memory responder: valid/ready fetch in, synchronous memory,
// in-order responses through a small FIFO, flush on redirect, boot loader port.
module imem_responder
  import imem_pkg::*;
#(
  parameter int unsigned  DEPTH_WORDS = 1024,
  localparam int unsigned AW          = $clog2(DEPTH_WORDS),
  parameter logic [31:0]  NOP_INSTR   = NOP_INSTR_DEFAULT
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic [31:0]   req_addr,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [31:0]   rsp_instr,
  output logic [31:0]   rsp_addr,
  output logic [1:0]    rsp_fault,
  input  logic          flush,
  input  logic          ld_en,
  input  logic [AW-1:0] ld_addr,
  input  logic [31:0]   ld_data
);

  logic [31:0] mem [DEPTH_WORDS];

  logic        vld_p1;
  logic [31:0] addr_p1;
  logic [1:0]  fault_p1;
  logic [31:0] rdata_p1;

  logic        accept;
  logic        push;
  logic        pop;
  logic [1:0]  fifo_count;
  rsp_entry_t  push_entry;
  rsp_entry_t  head;

  // Misalignment is reported ahead of out-of-range.
  function automatic logic [1:0] classify(input logic [31:0] a);
    if (a[1:0] != 2'b00) return FAULT_MISALIGN;
    if ({2'b00, a[31:2]} >= DEPTH_WORDS) return FAULT_RANGE;
    return FAULT_OK;
  endfunction

  // Room counts the entry still in stage 1, so an accepted fetch always has a
  // FIFO slot; rsp_ready never reaches this path.
  assign req_ready = rst && !ld_en &&
                     (({1'b0, fifo_count} + {2'b00, vld_p1}) < 3'd3);
  assign accept    = req_valid && req_ready;

  // ---- stage 1: accept and memory read ----

  // Stage-1 occupancy; a flush-cycle accept is the redirect target and survives.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vld_p1 <= 1'b0;
    else      vld_p1 <= accept;
  end

  // Stage-1 address and fault captured with the accepted request.
  always_ff @(posedge clk) begin
    if (accept) begin
      addr_p1  <= req_addr;
      fault_p1 <= classify(req_addr);
    end
  end

  // Loader writes and synchronous fetch reads; ld_en blocks accept, so they never collide.
  always_ff @(posedge clk) begin
    if (ld_en)  mem[ld_addr] <= ld_data;
    if (accept) rdata_p1 <= mem[req_addr[AW+1:2]];
  end

  // ---- stage 2: push into response FIFO ----

  assign push       = vld_p1;
  assign push_entry = '{instr: (fault_p1 == FAULT_OK) ? rdata_p1 : NOP_INSTR,
                        addr:  addr_p1,
                        fault: fault_p1};
  assign pop        = rsp_valid && rsp_ready;

  imem_rsp_fifo u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push       (push),
    .push_entry (push_entry),
    .pop        (pop),
    .flush      (flush),
    .head       (head),
    .count      (fifo_count)
  );

  // ---- response: FIFO head, zeroed when nothing is pending ----

  assign rsp_valid = (fifo_count != 2'd0);
  assign rsp_instr = rsp_valid ? head.instr : 32'd0;
  assign rsp_addr  = rsp_valid ? head.addr  : 32'd0;
  assign rsp_fault = rsp_valid ? head.fault : 2'd0;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: directed vectors, corner sequences, random vs model.
module tb_imem_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_instr;
  logic [31:0] rsp_addr;
  logic [1:0]  rsp_fault;
  logic        flush;
  logic        ld_en;
  logic [9:0]  ld_addr;
  logic [31:0] ld_data;

  imem_responder dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_addr  (req_addr),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_instr (rsp_instr),
    .rsp_addr  (rsp_addr),
    .rsp_fault (rsp_fault),
    .flush     (flush),
    .ld_en     (ld_en),
    .ld_addr   (ld_addr),
    .ld_data   (ld_data)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] instr;
    logic [1:0]  fault;
  } vec_t;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] addr;
    logic [1:0]  fault;
    bit          young;
  } ment_t;

  vec_t        vecs [7];
  logic [31:0] prog [4];
  logic [31:0] w8;
  ment_t       q [$];
  logic [31:0] mm [64];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 1'b0;
    flush     = 1'b0;
    ld_en     = 1'b0;
    rsp_ready = 1'b1;
  endtask

  task automatic load(input int w, input logic [31:0] d);
    req_valid = 1'b0;
    ld_en     = 1'b1;
    ld_addr   = 10'(w);
    ld_data   = d;
    tick();
    ld_en     = 1'b0;
  endtask

  // Single fetch on an empty pipe: response must appear exactly 2 cycles later.
  task automatic fetch_one(input logic [31:0] a, input logic [31:0] ei, input logic [1:0] ef);
    bit got;
    rsp_ready = 1'b1;
    req_valid = 1'b1;
    req_addr  = a;
    #1;
    chk("fetch_ready", 32'(req_ready), 32'd1);
    tick();
    req_valid = 1'b0;
    got = 1'b0;
    for (int lat = 1; lat <= 6 && !got; lat++) begin
      #1;
      if (rsp_valid) begin
        got = 1'b1;
        chk("fetch_latency", 32'(lat), 32'd2);
        chk("fetch_instr", rsp_instr, ei);
        chk("fetch_addr", rsp_addr, a);
        chk("fetch_fault", 32'(rsp_fault), 32'(ef));
      end
      tick();
    end
    if (!got) chk("fetch_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int acc, na, exp_idx, sel;
    bit acc4, got, accepted, exp_ready, exp_valid, pop;
    ment_t ne;

    prog[0] = 32'h0050_0093; prog[1] = 32'h0010_0113;
    prog[2] = 32'h0020_81B3; prog[3] = 32'h0000_0013;
    w8 = 32'h0080_0513;
    vecs[0] = '{32'h0000_0000, prog[0], 2'b00};
    vecs[1] = '{32'h0000_0004, prog[1], 2'b00};
    vecs[2] = '{32'h0000_0008, prog[2], 2'b00};
    vecs[3] = '{32'h0000_000C, prog[3], 2'b00};
    vecs[4] = '{32'h0000_0006, 32'h0000_0013, 2'b01};
    vecs[5] = '{32'h0000_1000, 32'h0000_0013, 2'b10};
    vecs[6] = '{32'h0000_1002, 32'h0000_0013, 2'b01};

    // Reset state
    rst = 1'b0; idle(); req_addr = '0; ld_addr = '0; ld_data = '0;
    #3;
    chk("rst_req_ready", 32'(req_ready), 32'd0);
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_rsp_instr", rsp_instr, 32'd0);
    chk("rst_rsp_addr", rsp_addr, 32'd0);
    chk("rst_rsp_fault", 32'(rsp_fault), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    chk("ready_after_reset", 32'(req_ready), 32'd1);

    // Program and vector table
    for (int i = 0; i < 4; i++) load(i, prog[i]);
    load(8, w8);
    for (int i = 0; i < 7; i++) fetch_one(vecs[i].addr, vecs[i].instr, vecs[i].fault);

    // Back-to-back stream
    idle();
    for (int c = 0; c < 7; c++) begin
      req_valid = (c < 4);
      req_addr  = 32'(4 * c);
      #1;
      if (c < 4) chk("stream_ready", 32'(req_ready), 32'd1);
      if (c >= 2 && c < 6) begin
        chk("stream_valid", 32'(rsp_valid), 32'd1);
        chk("stream_addr", rsp_addr, 32'(4 * (c - 2)));
        chk("stream_instr", rsp_instr, prog[c-2]);
      end else begin
        chk("stream_idle", 32'(rsp_valid), 32'd0);
      end
      tick();
    end

    // Backpressure: only 3 accepted with no pop
    idle(); rsp_ready = 1'b0; acc = 0; na = 0;
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'(4 * na);
      #1;
      if (req_ready) begin acc++; na++; end
      tick();
    end
    chk("bp_accepted", 32'(acc), 32'd3);
    for (int c = 0; c < 2; c++) begin
      #1;
      chk("bp_ready_low", 32'(req_ready), 32'd0);
      chk("bp_hold_valid", 32'(rsp_valid), 32'd1);
      chk("bp_hold_addr", rsp_addr, 32'd0);
      chk("bp_hold_instr", rsp_instr, prog[0]);
      tick();
    end
    rsp_ready = 1'b1; exp_idx = 0; acc4 = 1'b0;
    for (int c = 0; c < 10 && exp_idx < 4; c++) begin
      req_valid = !acc4;
      req_addr  = 32'h0000_000C;
      #1;
      if (c == 0) chk("bp_ready_before_pop", 32'(req_ready), 32'd0);
      if (req_valid && req_ready) acc4 = 1'b1;
      if (rsp_valid) begin
        chk("bp_order_addr", rsp_addr, 32'(4 * exp_idx));
        chk("bp_order_instr", rsp_instr, prog[exp_idx]);
        exp_idx++;
      end
      tick();
    end
    chk("bp_fourth_accepted", 32'(acc4), 32'd1);
    chk("bp_all_delivered", 32'(exp_idx), 32'd4);

    // Flush with redirect: 2 in FIFO plus stage 1, flush with rsp_ready=1
    idle(); rsp_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      req_valid = 1'b1;
      req_addr  = 32'(4 * c);
      tick();
    end
    flush = 1'b1; rsp_ready = 1'b1; req_valid = 1'b1; req_addr = 32'h0000_0020;
    #1;
    chk("flush_head_present", 32'(rsp_valid), 32'd1);
    tick();
    flush = 1'b0; got = 1'b0;
    for (int c = 0; c < 8 && !got; c++) begin
      #1;
      if (rsp_valid) begin
        got = 1'b1;
        chk("flush_addr", rsp_addr, 32'h0000_0020);
        chk("flush_instr", rsp_instr, w8);
      end
      accepted = req_valid && req_ready;
      tick();
      if (accepted) req_valid = 1'b0;
    end
    chk("flush_got", 32'(got), 32'd1);
    idle(); tick(); tick();

    // Loader blocks accept; read right after write sees new data
    ld_en = 1'b1; ld_addr = 10'd5; ld_data = 32'hCAFE_BABE;
    req_valid = 1'b1; req_addr = 32'h0000_0014;
    #1;
    chk("ld_blocks_ready", 32'(req_ready), 32'd0);
    tick();
    ld_en = 1'b0; req_valid = 1'b0;
    fetch_one(32'h0000_0014, 32'hCAFE_BABE, 2'b00);

    // Asynchronous reset mid-stream; memory persists
    idle(); rsp_ready = 1'b0; req_valid = 1'b1; req_addr = 32'h0000_0014;
    tick();
    req_addr = 32'h0000_0000;
    tick();
    req_valid = 1'b0;
    #1;
    chk("pre_reset_valid", 32'(rsp_valid), 32'd1);
    #1 rst = 1'b0;
    #1;
    chk("areset_valid", 32'(rsp_valid), 32'd0);
    chk("areset_ready", 32'(req_ready), 32'd0);
    tick(); tick();
    rst = 1'b1;
    tick();
    fetch_one(32'h0000_0014, 32'hCAFE_BABE, 2'b00);

    // Random traffic against queue model
    idle();
    for (int w = 0; w < 64; w++) begin
      mm[w] = $urandom;
      load(w, mm[w]);
    end
    tick(); tick();
    q.delete();
    for (int c = 0; c < 1500; c++) begin
      req_valid = ($urandom_range(0, 9) < 7);
      rsp_ready = ($urandom_range(0, 9) < 7);
      flush     = ($urandom_range(0, 19) == 0);
      ld_en     = ($urandom_range(0, 11) == 0);
      ld_addr   = 10'($urandom_range(0, 63));
      ld_data   = $urandom;
      sel       = int'($urandom_range(0, 9));
      if (sel < 7)       req_addr = 32'($urandom_range(0, 63)) << 2;
      else if (sel == 7) req_addr = (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
      else               req_addr = $urandom | 32'h0000_1000;
      #1;
      exp_ready = !ld_en && (q.size() < 3);
      exp_valid = (q.size() != 0) && !q[0].young;
      chk("rnd_ready", 32'(req_ready), 32'(exp_ready));
      chk("rnd_valid", 32'(rsp_valid), 32'(exp_valid));
      if (exp_valid) begin
        chk("rnd_instr", rsp_instr, q[0].instr);
        chk("rnd_addr", rsp_addr, q[0].addr);
        chk("rnd_fault", 32'(rsp_fault), 32'(q[0].fault));
      end
      accepted = req_valid && exp_ready;
      pop      = exp_valid && rsp_ready;
      ne.addr  = req_addr;
      ne.young = 1'b1;
      if (req_addr % 4 != 0)          ne.fault = 2'b01;
      else if (req_addr / 4 >= 1024)  ne.fault = 2'b10;
      else                            ne.fault = 2'b00;
      ne.instr = (ne.fault != 2'b00) ? 32'h0000_0013 : mm[int'(req_addr / 4)];
      tick();
      if (ld_en) mm[int'(ld_addr) % 64] = ld_data;
      if (flush)    q.delete();
      else if (pop) void'(q.pop_front());
      foreach (q[i]) q[i].young = 1'b0;
      if (accepted) q.push_back(ne);
    end
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
